regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard.sv | 79 +++++++
 tb/tb_regfile_scoreboard.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: dual-read register file with write bypass and per-register pending-writeback scoreboard
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB,
    input  logic                  ctrl_issueEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_issueReg,
    output logic                  busy_readRegA,
    output logic                  busy_readRegB,
    output logic                  hazard,
    output logic [ADDR_WIDTH:0]   busy_count
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam bit HAS_ZERO = (ZERO_REG != 0);

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      busyNext;
    logic [ADDR_WIDTH:0]   countNext;
    logic                  writeValid;
    logic                  issueValid;
    logic                  bypassA;
    logic                  bypassB;
    logic                  zeroA;
    logic                  zeroB;

    assign writeValid = ctrl_writeEnable && !(HAS_ZERO && ctrl_writeReg == '0);
    assign issueValid = ctrl_issueEnable && !(HAS_ZERO && ctrl_issueReg == '0);
    assign bypassA    = writeValid && ctrl_writeReg == ctrl_readRegA;
    assign bypassB    = writeValid && ctrl_writeReg == ctrl_readRegB;
    assign zeroA      = HAS_ZERO && ctrl_readRegA == '0;
    assign zeroB      = HAS_ZERO && ctrl_readRegB == '0;

    // Next busy vector: writeback clears, then issue sets so a same-cycle issue wins
    always_comb begin
        busyNext = busy;
        if (writeValid) busyNext[ctrl_writeReg] = 1'b0;
        if (issueValid) busyNext[ctrl_issueReg] = 1'b1;
    end

    // Popcount of the next busy vector so busy_count tracks the bits after each edge
    always_comb begin
        countNext = '0;
        for (int i = 0; i < DEPTH; i++)
            countNext = countNext + {{ADDR_WIDTH{1'b0}}, busyNext[i]};
    end

    // Register array, scoreboard and pending count; reset clears everything asynchronously
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            busy       <= '0;
            busy_count <= '0;
        end else begin
            if (writeValid) regs[ctrl_writeReg] <= data_writeReg;
            busy       <= busyNext;
            busy_count <= countNext;
        end
    end

    // Combinational read ports with same-cycle writeback bypass, forced to zero during reset
    always_comb begin
        data_readRegA = ctrl_reset ? '0 : bypassA ? data_writeReg : zeroA ? '0 : regs[ctrl_readRegA];
        data_readRegB = ctrl_reset ? '0 : bypassB ? data_writeReg : zeroB ? '0 : regs[ctrl_readRegB];
        busy_readRegA = !ctrl_reset && !zeroA && busy[ctrl_readRegA] && !bypassA;
        busy_readRegB = !ctrl_reset && !zeroB && busy[ctrl_readRegB] && !bypassB;
        hazard        = busy_readRegA || busy_readRegB;
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed scoreboard bench for regfile_scoreboard
module tb_regfile_scoreboard;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clock = 1'b0;
    logic          ctrl_reset;
    logic          ctrl_writeEnable;
    logic [AW-1:0] ctrl_writeReg;
    logic [DW-1:0] data_writeReg;
    logic [AW-1:0] ctrl_readRegA;
    logic [AW-1:0] ctrl_readRegB;
    logic [DW-1:0] data_readRegA;
    logic [DW-1:0] data_readRegB;
    logic          ctrl_issueEnable;
    logic [AW-1:0] ctrl_issueReg;
    logic          busy_readRegA;
    logic          busy_readRegB;
    logic          hazard;
    logic [AW:0]   busy_count;

    typedef struct {
        string         tag;
        logic [DW-1:0] val;
    } exp_t;

    exp_t sbq[$];
    int   compared   = 0;
    int   mismatched = 0;

    regfile_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1)) dut (
        .clock(clock),
        .ctrl_reset(ctrl_reset),
        .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg),
        .ctrl_readRegA(ctrl_readRegA),
        .ctrl_readRegB(ctrl_readRegB),
        .data_readRegA(data_readRegA),
        .data_readRegB(data_readRegB),
        .ctrl_issueEnable(ctrl_issueEnable),
        .ctrl_issueReg(ctrl_issueReg),
        .busy_readRegA(busy_readRegA),
        .busy_readRegB(busy_readRegB),
        .hazard(hazard),
        .busy_count(busy_count)
    );

    always #5 clock = ~clock;

    task automatic push(input string tag, input logic [DW-1:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sbq.push_back(e);
    endtask

    task automatic pop(input logic [DW-1:0] obs);
        exp_t e;
        compared++;
        assert (sbq.size() != 0) else begin
            mismatched++;
            $error("FAIL sb_empty: observed %0h required an expectation", obs);
        end
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            assert (obs === e.val) else begin
                mismatched++;
                $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic drive(input logic w, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                         input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                         input logic i, input logic [AW-1:0] ir);
        @(negedge clock);
        ctrl_writeEnable = w;
        ctrl_writeReg    = wr;
        data_writeReg    = wd;
        ctrl_readRegA    = ra;
        ctrl_readRegB    = rb;
        ctrl_issueEnable = i;
        ctrl_issueReg    = ir;
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish required finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ctrl_reset = 1'b1;
        ctrl_writeEnable = 1'b0; ctrl_writeReg = '0; data_writeReg = '0;
        ctrl_readRegA = '0; ctrl_readRegB = '0; ctrl_issueEnable = 1'b0; ctrl_issueReg = '0;

        drive(1, 5, 32'hCAFEF00D, 5, 5, 1, 5);
        push("rst_dataA_bypass_off", 0); pop(data_readRegA);
        push("rst_dataB_bypass_off", 0); pop(data_readRegB);
        push("rst_busyA", 0);            pop(busy_readRegA);
        push("rst_hazard", 0);           pop(hazard);
        push("rst_count", 0);            pop(busy_count);
        drive(1, 5, 32'hCAFEF00D, 5, 5, 1, 5);
        push("rst_edge_count", 0);       pop(busy_count);
        drive(0, 0, 0, 5, 5, 0, 0);
        ctrl_reset = 1'b0;
        drive(0, 0, 0, 5, 5, 0, 0);
        push("rst_discard_r5", 0);       pop(data_readRegA);
        push("rst_discard_count", 0);    pop(busy_count);

        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        push("r5_write", 32'hDEADBEEF);
        drive(0, 0, 0, 5, 0, 0, 0);
        pop(data_readRegA);
        push("r5_busyA", 0);             pop(busy_readRegA);

        drive(1, 7, 32'h12345678, 5, 7, 0, 0);
        push("r7_bypassB", 32'h12345678); pop(data_readRegB);
        push("r5_holdA", 32'hDEADBEEF);   pop(data_readRegA);

        drive(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
        push("r0_bypass_off", 0);        pop(data_readRegA);
        drive(0, 0, 0, 0, 0, 1, 0);
        push("r0_read", 0);              pop(data_readRegA);
        drive(0, 0, 0, 0, 7, 0, 0);
        push("r0_issue_count", 0);       pop(busy_count);
        push("r0_busyA", 0);             pop(busy_readRegA);
        push("r7_readB", 32'h12345678);  pop(data_readRegB);

        drive(0, 0, 0, 3, 0, 1, 3);
        push("r3_issue_sameA", 0);       pop(busy_readRegA);
        push("r3_issue_hazard", 0);      pop(hazard);
        push("r3_count_after_issue", 1);
        drive(0, 0, 0, 3, 0, 0, 0);
        pop(busy_count);
        push("r3_busyA", 1);             pop(busy_readRegA);
        push("r3_hazard", 1);            pop(hazard);
        drive(1, 3, 32'h55, 3, 0, 0, 0);
        push("r3_wb_busyA", 0);          pop(busy_readRegA);
        push("r3_wb_dataA", 32'h55);     pop(data_readRegA);
        push("r3_wb_hazard", 0);         pop(hazard);
        push("r3_wb_count_same", 1);     pop(busy_count);
        push("r3_count_after_wb", 0);
        drive(0, 0, 0, 3, 0, 0, 0);
        pop(busy_count);
        push("r3_dataA", 32'h55);        pop(data_readRegA);

        drive(1, 9, 32'hA5, 9, 9, 1, 9);
        push("r9_bypassA", 32'hA5);      pop(data_readRegA);
        push("r9_bypassB", 32'hA5);      pop(data_readRegB);
        push("r9_same_busyA", 0);        pop(busy_readRegA);
        drive(0, 0, 0, 9, 0, 0, 0);
        push("r9_dataA", 32'hA5);        pop(data_readRegA);
        push("r9_issue_wins", 1);        pop(busy_readRegA);
        push("r9_count", 1);             pop(busy_count);
        drive(0, 0, 0, 9, 0, 1, 9);
        push("r9_reissue_busyA", 1);     pop(busy_readRegA);
        drive(0, 0, 0, 9, 0, 0, 0);
        push("r9_reissue_count", 1);     pop(busy_count);
        drive(1, 9, 32'h1, 9, 0, 0, 0);
        push("r9_wb_busyA", 0);          pop(busy_readRegA);
        push("r9_wb_dataA", 32'h1);      pop(data_readRegA);
        drive(0, 0, 0, 9, 0, 0, 0);
        push("r9_single_wb_count", 0);   pop(busy_count);
        push("r9_single_wb_busy", 0);    pop(busy_readRegA);

        drive(1, 12, 32'hBEEF, 0, 12, 0, 0);
        push("r12_bypassB", 32'hBEEF);   pop(data_readRegB);
        push("r12_busyB", 0);            pop(busy_readRegB);
        drive(0, 0, 0, 12, 0, 0, 0);
        push("r12_count", 0);            pop(busy_count);
        push("r12_dataA", 32'hBEEF);     pop(data_readRegA);

        drive(1, 1, 32'h11, 0, 0, 0, 0);
        drive(1, 2, 32'h22, 0, 0, 0, 0);
        drive(1, 4, 32'h44, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 1, 2);
        drive(0, 0, 0, 0, 0, 1, 4);
        drive(0, 0, 0, 1, 2, 0, 0);
        push("multi_count", 3);          pop(busy_count);
        push("multi_busyA", 1);          pop(busy_readRegA);
        push("multi_busyB", 1);          pop(busy_readRegB);
        push("multi_dataA", 32'h11);     pop(data_readRegA);
        push("multi_dataB", 32'h22);     pop(data_readRegB);
        drive(0, 0, 0, 0, 2, 0, 0);
        push("hazard_b_only", 1);        pop(hazard);
        push("hazard_b_busyA", 0);       pop(busy_readRegA);
        drive(1, 1, 32'h77, 0, 4, 1, 6);
        push("swap_busyB", 1);           pop(busy_readRegB);
        push("swap_count_same", 3);      pop(busy_count);
        drive(0, 0, 0, 1, 6, 0, 0);
        push("swap_count", 3);           pop(busy_count);
        push("swap_busyA", 0);           pop(busy_readRegA);
        push("swap_dataA", 32'h77);      pop(data_readRegA);
        push("swap_busyB6", 1);          pop(busy_readRegB);

        #1;
        ctrl_reset = 1'b1;
        #1;
        push("async_dataA", 0);          pop(data_readRegA);
        push("async_dataB", 0);          pop(data_readRegB);
        push("async_busyB", 0);          pop(busy_readRegB);
        push("async_hazard", 0);         pop(hazard);
        push("async_count", 0);          pop(busy_count);
        drive(1, 4, 32'h1234, 4, 4, 1, 4);
        push("hold_bypass_off", 0);      pop(data_readRegA);
        push("hold_busyA", 0);           pop(busy_readRegA);
        push("hold_count", 0);           pop(busy_count);
        drive(0, 0, 0, 4, 2, 0, 0);
        ctrl_reset = 1'b0;
        drive(0, 0, 0, 4, 2, 0, 0);
        push("post_rst_r4", 0);          pop(data_readRegA);
        push("post_rst_r2", 0);          pop(data_readRegB);
        push("post_rst_count", 0);       pop(busy_count);
        push("post_rst_busyA", 0);       pop(busy_readRegA);

        compared++;
        assert (sbq.size() == 0) else begin
            mismatched++;
            $error("FAIL sb_drain: observed %0d left required 0", sbq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
